// File: rtl/gate_chk_pkg.sv
// Shared types and constants for the gate vector checker: FSM states, common
// 2-input truth tables and sizing limits.
package gate_chk_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_e;

    // Bit k of each table is the expected gate output for input vector k.
    localparam logic [3:0] TT_NAND2 = 4'b0111;
    localparam logic [3:0] TT_NOR2  = 4'b0001;
    localparam logic [3:0] TT_XOR2  = 4'b0110;
    localparam logic [3:0] TT_AND2  = 4'b1000;

    localparam int MAX_N_IN = 4;
    localparam int SETTLE_W = 4;

endpackage

// File: rtl/gate_chk_settle_cnt.sv
// Settle-time counter: strobes sample_o on the cycle a vector has been held
// for SETTLE_CYC+1 cycles, then restarts for the next vector.
module gate_chk_settle_cnt
    import gate_chk_pkg::*;
#(
    parameter int SETTLE_CYC = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic clear_i,
    input  logic en_i,
    output logic sample_o
);

    localparam logic [SETTLE_W-1:0] LAST_CNT = SETTLE_W'(SETTLE_CYC);

    logic [SETTLE_W-1:0] cnt_q, cnt_d;

    assign sample_o = en_i && (cnt_q == LAST_CNT);

    always_comb begin
        cnt_d = cnt_q;
        if (clear_i || sample_o) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/gate_vector_checker.sv
// Sweeps every input vector of an N_IN-input gate in ascending order and scores
// the sampled output against TRUTH. GATE_CHK_FIRSTFAIL_EN adds first-failure capture.
module gate_vector_checker
    import gate_chk_pkg::*;
#(
    parameter int                     N_IN       = 2,
    parameter logic [(2**N_IN)-1:0]   TRUTH      = TT_NAND2,
    parameter int                     SETTLE_CYC = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic                    dut_y,
    output logic [N_IN-1:0]         stim,
    output logic                    busy,
    output logic                    done,
    output logic                    pass,
    output logic [N_IN:0]           err_count,
    output logic [(2**N_IN)-1:0]    mismatch_vec
`ifdef GATE_CHK_FIRSTFAIL_EN
    ,
    output logic [N_IN-1:0]         first_fail_idx,
    output logic                    first_fail_vld
`endif
);

    localparam int              NV       = 2**N_IN;
    localparam logic [N_IN-1:0] LAST_IDX = N_IN'(NV - 1);

    state_e            state_q, state_d;
    logic [N_IN-1:0]   stim_q, stim_d;
    logic [N_IN:0]     err_q, err_d;
    logic [NV-1:0]     mvec_q, mvec_d;
    logic              pass_q, pass_d;
    logic              accept;
    logic              run_en;
    logic              sample;
    logic              miss;

    assign run_en = (state_q == RUN);

    gate_chk_settle_cnt #(
        .SETTLE_CYC (SETTLE_CYC)
    ) u_settle (
        .clk      (clk),
        .rst      (rst),
        .clear_i  (accept),
        .en_i     (run_en),
        .sample_o (sample)
    );

`ifdef GATE_CHK_FIRSTFAIL_EN
    logic [N_IN-1:0] ff_idx_q, ff_idx_d;
    logic            ff_vld_q, ff_vld_d;

    always_comb begin
        ff_idx_d = ff_idx_q;
        ff_vld_d = ff_vld_q;
        if (accept) begin
            ff_idx_d = '0;
            ff_vld_d = 1'b0;
        end else if (miss && !ff_vld_q) begin
            ff_idx_d = stim_q;
            ff_vld_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ff_idx_q <= '0;
            ff_vld_q <= 1'b0;
        end else begin
            ff_idx_q <= ff_idx_d;
            ff_vld_q <= ff_vld_d;
        end
    end

    assign first_fail_idx = ff_idx_q;
    assign first_fail_vld = ff_vld_q;
`endif

    always_comb begin
        state_d = state_q;
        stim_d  = stim_q;
        err_d   = err_q;
        mvec_d  = mvec_q;
        pass_d  = pass_q;
        accept  = 1'b0;
        miss    = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    accept  = 1'b1;
                    state_d = RUN;
                    stim_d  = '0;
                    err_d   = '0;
                    mvec_d  = '0;
                    pass_d  = 1'b0;
                end
            end
            RUN: begin
                if (sample) begin
                    miss = (dut_y != TRUTH[stim_q]);
                    if (miss) begin
                        err_d          = err_q + 1'b1;
                        mvec_d[stim_q] = 1'b1;
                    end
                    // pass must reflect the final vector's result, hence err_d.
                    if (stim_q == LAST_IDX) begin
                        state_d = DONE;
                        pass_d  = (err_d == '0);
                    end else begin
                        stim_d = stim_q + 1'b1;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            stim_q  <= '0;
            err_q   <= '0;
            mvec_q  <= '0;
            pass_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            stim_q  <= stim_d;
            err_q   <= err_d;
            mvec_q  <= mvec_d;
            pass_q  <= pass_d;
        end
    end

    assign stim         = stim_q;
    assign busy         = (state_q != IDLE);
    assign done         = (state_q == DONE);
    assign pass         = pass_q;
    assign err_count    = err_q;
    assign mismatch_vec = mvec_q;

endmodule

// File: tb/tb_gate_vector_checker.sv
// Bench for gate_vector_checker: three configurations driven by randomized gate
// models, scored against a cycle-level model of the sweep schedule.
module tb_gate_vector_checker;
    import gate_chk_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;
    logic start_w [3];
    logic [7:0] gtt [3];

    logic [1:0] stim_a, stim_b;
    logic [2:0] stim_c;
    logic [2:0] ec_a, ec_b;
    logic [3:0] ec_c;
    logic [3:0] mv_a, mv_b;
    logic [7:0] mv_c;
    logic busy_w [3];
    logic done_w [3];
    logic pass_w [3];
    logic y_w [3];

    logic [2:0] stim_w [3];
    logic [3:0] ec_w [3];
    logic [7:0] mv_w [3];

    int         nin_t    [3] = '{2, 2, 3};
    int         settle_t [3] = '{1, 0, 3};
    logic [7:0] truth_t  [3] = '{8'(TT_NAND2), 8'(TT_NAND2), 8'b0111_1111};

    int n_cmp = 0;
    int n_bad = 0;

    // Gate models: each gate's output is a bench-chosen truth table of its inputs.
    assign y_w[0] = gtt[0][stim_a];
    assign y_w[1] = gtt[1][stim_b];
    assign y_w[2] = gtt[2][stim_c];

    assign stim_w[0] = {1'b0, stim_a};
    assign stim_w[1] = {1'b0, stim_b};
    assign stim_w[2] = stim_c;
    assign ec_w[0]   = {1'b0, ec_a};
    assign ec_w[1]   = {1'b0, ec_b};
    assign ec_w[2]   = ec_c;
    assign mv_w[0]   = {4'b0, mv_a};
    assign mv_w[1]   = {4'b0, mv_b};
    assign mv_w[2]   = mv_c;

`ifdef GATE_CHK_FIRSTFAIL_EN
    logic [1:0] ffi_a, ffi_b;
    logic [2:0] ffi_c;
    logic [2:0] ffi_w [3];
    logic       ffv_w [3];
    assign ffi_w[0] = {1'b0, ffi_a};
    assign ffi_w[1] = {1'b0, ffi_b};
    assign ffi_w[2] = ffi_c;
`endif

    gate_vector_checker #(.N_IN(2), .TRUTH(TT_NAND2), .SETTLE_CYC(1)) u_a (
        .clk(clk), .rst(rst), .start(start_w[0]), .dut_y(y_w[0]), .stim(stim_a),
        .busy(busy_w[0]), .done(done_w[0]), .pass(pass_w[0]), .err_count(ec_a),
        .mismatch_vec(mv_a)
`ifdef GATE_CHK_FIRSTFAIL_EN
        , .first_fail_idx(ffi_a), .first_fail_vld(ffv_w[0])
`endif
    );

    gate_vector_checker #(.N_IN(2), .TRUTH(TT_NAND2), .SETTLE_CYC(0)) u_b (
        .clk(clk), .rst(rst), .start(start_w[1]), .dut_y(y_w[1]), .stim(stim_b),
        .busy(busy_w[1]), .done(done_w[1]), .pass(pass_w[1]), .err_count(ec_b),
        .mismatch_vec(mv_b)
`ifdef GATE_CHK_FIRSTFAIL_EN
        , .first_fail_idx(ffi_b), .first_fail_vld(ffv_w[1])
`endif
    );

    gate_vector_checker #(.N_IN(3), .TRUTH(8'b0111_1111), .SETTLE_CYC(3)) u_c (
        .clk(clk), .rst(rst), .start(start_w[2]), .dut_y(y_w[2]), .stim(stim_c),
        .busy(busy_w[2]), .done(done_w[2]), .pass(pass_w[2]), .err_count(ec_c),
        .mismatch_vec(mv_c)
`ifdef GATE_CHK_FIRSTFAIL_EN
        , .first_fail_idx(ffi_c), .first_fail_vld(ffv_w[2])
`endif
    );

    // One full sweep on checker d with gate table tt. Entered and left just after
    // a negedge. mid_t pulses start so it is seen at edge E0+mid_t; hold keeps
    // start high throughout so the next sweep is accepted right after DONE.
    task automatic sweep(input int d, input logic [7:0] tt, input int mid_t, input bit hold);
        int n, s, nv, len, nsamp, exp_stim, exp_ec, exp_ffi;
        logic [7:0] mism, exp_mv;
        bit exp_pass, exp_busy, exp_done;
        n    = nin_t[d];
        s    = settle_t[d];
        nv   = 1 << n;
        len  = nv * (s + 1);
        mism = (tt ^ truth_t[d]) & 8'((1 << nv) - 1);
        gtt[d]     = tt;
        start_w[d] = 1'b1;
        for (int t = 0; t <= len + 1; t++) begin
            @(negedge clk);
            nsamp = t / (s + 1);
            if (nsamp > nv) nsamp = nv;
            exp_mv   = mism & 8'((1 << nsamp) - 1);
            exp_ec   = $countones(exp_mv);
            exp_stim = (t < len) ? t / (s + 1) : nv - 1;
            exp_busy = (t <= len);
            exp_done = (t == len);
            exp_pass = (t >= len) && (exp_ec == 0);
            n_cmp += 6;
            if (stim_w[d] !== 3'(exp_stim)) begin
                n_bad++; $display("FAIL stim d=%0d t=%0d: got %0d want %0d", d, t, stim_w[d], exp_stim);
            end
            if (busy_w[d] !== exp_busy) begin
                n_bad++; $display("FAIL busy d=%0d t=%0d: got %0b want %0b", d, t, busy_w[d], exp_busy);
            end
            if (done_w[d] !== exp_done) begin
                n_bad++; $display("FAIL done d=%0d t=%0d: got %0b want %0b", d, t, done_w[d], exp_done);
            end
            if (ec_w[d] !== 4'(exp_ec)) begin
                n_bad++; $display("FAIL err_count d=%0d t=%0d: got %0d want %0d", d, t, ec_w[d], exp_ec);
            end
            if (mv_w[d] !== exp_mv) begin
                n_bad++; $display("FAIL mismatch_vec d=%0d t=%0d: got %0h want %0h", d, t, mv_w[d], exp_mv);
            end
            if (pass_w[d] !== exp_pass) begin
                n_bad++; $display("FAIL pass d=%0d t=%0d: got %0b want %0b", d, t, pass_w[d], exp_pass);
            end
`ifdef GATE_CHK_FIRSTFAIL_EN
            exp_ffi = 0;
            for (int k = 7; k >= 0; k--) if (exp_mv[k]) exp_ffi = k;
            n_cmp++;
            if (ffv_w[d] !== (exp_mv != 8'h00)) begin
                n_bad++; $display("FAIL ff_vld d=%0d t=%0d: got %0b want %0b", d, t, ffv_w[d], exp_mv != 8'h00);
            end
            if (exp_mv != 8'h00) begin
                n_cmp++;
                if (ffi_w[d] !== 3'(exp_ffi)) begin
                    n_bad++; $display("FAIL ff_idx d=%0d t=%0d: got %0d want %0d", d, t, ffi_w[d], exp_ffi);
                end
            end
`else
            exp_ffi = 0;
`endif
            start_w[d] = hold || (t == mid_t - 1);
        end
        $display("sweep d=%0d tt=%02h settle=%0d: err_count=%0d mismatch_vec=%02h pass=%0b",
                 d, tt, s, ec_w[d], mv_w[d], pass_w[d]);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        for (int d = 0; d < 3; d++) begin
            start_w[d] = 1'b0;
            gtt[d]     = 8'h00;
        end
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        for (int d = 0; d < 3; d++) begin
            n_cmp++;
            if ({stim_w[d], busy_w[d], done_w[d], pass_w[d], ec_w[d], mv_w[d]} !== 18'h0) begin
                n_bad++;
                $display("FAIL reset_values d=%0d: got stim=%0d busy=%0b done=%0b pass=%0b ec=%0d mv=%0h want all 0",
                         d, stim_w[d], busy_w[d], done_w[d], pass_w[d], ec_w[d], mv_w[d]);
            end
        end
        $display("reset: outputs of all checkers sampled");
    endtask

    task automatic test_nand2_correct();
        sweep(0, 8'(TT_NAND2), -1, 1'b0);
    endtask

    task automatic test_and2_model();
        sweep(0, 8'(TT_AND2), -1, 1'b0);
    endtask

    task automatic test_stuck_high();
        sweep(1, 8'h0F, -1, 1'b0);
    endtask

    task automatic test_start_in_run();
        sweep(0, 8'(TT_XOR2), 3, 1'b0);
    endtask

    task automatic test_back_to_back();
        sweep(0, 8'(TT_NOR2), -1, 1'b1);
        sweep(0, 8'(TT_NAND2), -1, 1'b0);
    endtask

    task automatic test_reset_mid_sweep();
        gtt[0]     = 8'(TT_AND2);
        start_w[0] = 1'b1;
        for (int t = 0; t <= 4; t++) begin
            @(negedge clk);
            start_w[0] = 1'b0;
        end
        n_cmp++;
        if (ec_w[0] !== 4'd2) begin
            n_bad++; $display("FAIL pre_abort_err_count: got %0d want 2", ec_w[0]);
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        n_cmp++;
        if ({stim_w[0], busy_w[0], done_w[0], pass_w[0], ec_w[0], mv_w[0]} !== 18'h0) begin
            n_bad++;
            $display("FAIL abort_values: got stim=%0d busy=%0b done=%0b pass=%0b ec=%0d mv=%0h want all 0",
                     stim_w[0], busy_w[0], done_w[0], pass_w[0], ec_w[0], mv_w[0]);
        end
        for (int t = 0; t < 10; t++) begin
            @(negedge clk);
            n_cmp++;
            if (done_w[0] !== 1'b0 || busy_w[0] !== 1'b0) begin
                n_bad++; $display("FAIL abort_quiet t=%0d: got done=%0b busy=%0b want 0 0", t, done_w[0], busy_w[0]);
            end
        end
        $display("abort: checker 0 reset mid-sweep at E0+5");
        sweep(0, 8'(TT_NAND2), -1, 1'b0);
    endtask

    task automatic test_nand3();
        sweep(2, 8'b0111_1111, -1, 1'b0);
    endtask

    task automatic test_random();
        int d;
        for (int i = 0; i < 9; i++) begin
            d = $urandom_range(0, 2);
            sweep(d, 8'($urandom), -1, 1'b0);
        end
    endtask

    initial begin
        test_reset();
        test_nand2_correct();
        test_and2_model();
        test_stuck_high();
        test_start_in_run();
        test_back_to_back();
        test_reset_mid_sweep();
        test_nand3();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
